// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// The FSM state encoding lives here so the top and any future users agree on it.
package pwm_capture_pkg;

    // Default width of the period/high-time counters and results
    localparam int CNT_W_DEFAULT    = 16;

    // Default glitch-filter length (only meaningful with PWM_CAPTURE_GLITCH_FILTER_EN)
    localparam int FILT_LEN_DEFAULT = 3;

    // Depth of the metastability synchronizer on the raw PWM input
    localparam int SYNC_STAGES      = 2;

    // Measurement FSM states; prefixed so they never collide with port names
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } state_t;

endpackage : pwm_capture_pkg

// File: rtl/pwm_sync_edge.sv
// Input conditioning for the PWM capture block: two-flop synchronizer,
// optional glitch filter and single-cycle rise/fall pulse generation.
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to compile in the
// FILT_LEN-sample glitch filter; without it FILT_LEN has no effect.
module pwm_sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PWM_IN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_raw;
    logic                   level_int;
    logic                   prev_reg;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], PWM_IN};
        end
    end

    assign level_raw = sync_reg[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Counter needs to reach FILT_LEN-1, so size it for FILT_LEN
    localparam int FILT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic              filt_reg;
    logic [FILT_W-1:0] filt_cnt_reg;

    // Accept a new level only after FILT_LEN consecutive differing samples
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            filt_reg     <= 1'b0;
            filt_cnt_reg <= '0;
        end else if (level_raw == filt_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == FILT_W'(FILT_LEN - 1)) begin
            filt_reg     <= level_raw;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + FILT_W'(1);
        end
    end

    assign level_int = filt_reg;
`else
    assign level_int = level_raw;
`endif

    // Remember last cycle's conditioned level for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level_int;
        end
    end

    // Edge pulses are combinational so the FSM acts on them in the same cycle
    assign RISE  = level_int & ~prev_reg;
    assign FALL  = ~level_int & prev_reg;
    assign LEVEL = level_int;

endmodule : pwm_sync_edge

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period of PWM_IN in
// CLK cycles, pulses VALID on each completed period and flags STUCK when no
// edge arrives before the period counter saturates.
// Optional feature: PWM_CAPTURE_GLITCH_FILTER_EN enables the input glitch
// filter inside pwm_sync_edge (adds FILT_LEN cycles of latency).
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PWM_IN,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] PERIOD,
    output logic             VALID,
    output logic             STUCK,
    output logic             LEVEL
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise;
    logic             fall;
    logic             level;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_sat;
    logic [CNT_W-1:0] high_reg;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic             valid_reg;
    logic             stuck_reg;

    pwm_sync_edge #(
        .FILT_LEN (FILT_LEN)
    ) u_sync_edge (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .PWM_IN (PWM_IN),
        .LEVEL  (level),
        .RISE   (rise),
        .FALL   (fall)
    );

    // Next period count: restart on a rising edge (or on leaving STUCK),
    // otherwise count up and saturate instead of wrapping
    always_comb begin
        cnt_next = cnt_reg;
        if (rise || (state_reg == ST_STUCK && fall)) begin
            cnt_next = CNT_ONE;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
        cnt_sat = (cnt_next == CNT_MAX);
    end

    // Period counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Measurement FSM with registered results, VALID and STUCK
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_IDLE;
            high_reg     <= '0;
            high_cnt_reg <= '0;
            period_reg   <= '0;
            valid_reg    <= 1'b0;
            stuck_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // First rising edge only starts a measurement
                    if (rise) begin
                        state_reg <= ST_HIGH;
                    end else if (cnt_sat) begin
                        state_reg <= ST_STUCK;
                        stuck_reg <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        high_reg  <= cnt_reg;
                        state_reg <= ST_LOW;
                    end else if (cnt_sat) begin
                        state_reg <= ST_STUCK;
                        stuck_reg <= 1'b1;
                    end
                end
                ST_LOW: begin
                    // A rising edge closes a full period: publish it
                    if (rise) begin
                        period_reg   <= cnt_reg;
                        high_cnt_reg <= high_reg;
                        valid_reg    <= 1'b1;
                        state_reg    <= ST_HIGH;
                    end else if (cnt_sat) begin
                        state_reg <= ST_STUCK;
                        stuck_reg <= 1'b1;
                    end
                end
                ST_STUCK: begin
                    // Any edge ends the stuck condition; no result is published
                    if (rise) begin
                        state_reg <= ST_HIGH;
                        stuck_reg <= 1'b0;
                    end else if (fall) begin
                        state_reg <= ST_IDLE;
                        stuck_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    stuck_reg <= 1'b0;
                end
            endcase
        end
    end

    assign HIGH_CNT = high_cnt_reg;
    assign PERIOD   = period_reg;
    assign VALID    = valid_reg;
    assign STUCK    = stuck_reg;
    assign LEVEL    = level;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (CNT_W=8) using an expected-result queue.
module tb_pwm_capture;

    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 3;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    logic             CLK;
    logic             RST_N;
    logic             PWM_IN;
    logic [CNT_W-1:0] HIGH_CNT;
    logic [CNT_W-1:0] PERIOD;
    logic             VALID;
    logic             STUCK;
    logic             LEVEL;

    typedef struct {
        int h;
        int p;
        int rc;
    } exp_t;

    exp_t sb_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   cyc     = 0;
    bit   have_prev = 0;
    int   prev_h  = 0;
    int   prev_l  = 0;
    int   last_h  = 0;
    int   last_p  = 0;

    pwm_capture #(
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PWM_IN   (PWM_IN),
        .HIGH_CNT (HIGH_CNT),
        .PERIOD   (PERIOD),
        .VALID    (VALID),
        .STUCK    (STUCK),
        .LEVEL    (LEVEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a rising edge; the period it closes (if any) becomes an expectation
    task automatic start_rise();
        exp_t e;
        PWM_IN = 1'b1;
        if (have_prev) begin
            e.h  = prev_h;
            e.p  = prev_h + prev_l;
            e.rc = cyc;
            sb_q.push_back(e);
            last_h = e.h;
            last_p = e.p;
        end
    endtask

    task automatic pwm_cycle(input int h, input int l);
        start_rise();
        repeat (h) tick();
        PWM_IN = 1'b0;
        repeat (l) tick();
        have_prev = 1;
        prev_h    = h;
        prev_l    = l;
    endtask

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    task automatic pwm_glitch_cycle();
        start_rise();
        repeat (30) tick();
        PWM_IN = 1'b0;
        repeat (20) tick();
        PWM_IN = 1'b1;
        repeat (2) tick();
        PWM_IN = 1'b0;
        repeat (48) tick();
        have_prev = 1;
        prev_h    = 30;
        prev_l    = 70;
    endtask
`endif

    // Scoreboard: every VALID must match the oldest pending expectation
    always @(negedge CLK) begin
        if (RST_N && VALID) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("valid: cycle=%0d high_cnt=%0d period=%0d exp=%0d/%0d",
                         cyc, HIGH_CNT, PERIOD, e.h, e.p);
                check("high_cnt", 32'(HIGH_CNT), 32'(e.h));
                check("period", 32'(PERIOD), 32'(e.p));
                check("latency", 32'(cyc - e.rc), 32'(LAT));
            end
        end
    end

    initial begin
        RST_N  = 1'b0;
        PWM_IN = 1'b0;
        repeat (3) tick();
        check("rst_high_cnt", 32'(HIGH_CNT), 32'd0);
        check("rst_period", 32'(PERIOD), 32'd0);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_stuck", 32'(STUCK), 32'd0);
        check("rst_level", 32'(LEVEL), 32'd0);
        RST_N = 1'b1;
        repeat (5) tick();

        // Steady 30/70 stream, then a duty change to 80/20
        for (int i = 0; i < 5; i++) pwm_cycle(30, 70);
        for (int i = 0; i < 3; i++) pwm_cycle(80, 20);

        // Held high long enough to saturate the 8-bit counter
        start_rise();
        have_prev = 0;
        repeat (250) tick();
        check("stuck_early", 32'(STUCK), 32'd0);
        repeat (50) tick();
        check("stuck_set", 32'(STUCK), 32'd1);
        check("stuck_level", 32'(LEVEL), 32'd1);
        check("stuck_high_hold", 32'(HIGH_CNT), 32'(last_h));
        check("stuck_period_hold", 32'(PERIOD), 32'(last_p));
        PWM_IN = 1'b0;
        repeat (20) tick();
        check("stuck_clear", 32'(STUCK), 32'd0);
        check("low_level", 32'(LEVEL), 32'd0);
        for (int i = 0; i < 2; i++) pwm_cycle(10, 20);

        // Fastest waveform
        for (int i = 0; i < 10; i++) pwm_cycle(1, 1);

        // Reset in the middle of a high phase
        start_rise();
        repeat (10) tick();
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_high_cnt", 32'(HIGH_CNT), 32'd0);
        check("mid_rst_period", 32'(PERIOD), 32'd0);
        check("mid_rst_valid", 32'(VALID), 32'd0);
        check("mid_rst_stuck", 32'(STUCK), 32'd0);
        check("mid_rst_level", 32'(LEVEL), 32'd0);
        tick();
        PWM_IN    = 1'b0;
        have_prev = 0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) pwm_cycle(30, 70);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        for (int i = 0; i < 4; i++) pwm_glitch_cycle();
`endif

        repeat (20) tick();
        check("pending", 32'(sb_q.size()), 32'd0);
        check("final_stuck", 32'(STUCK), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_pwm_capture

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of measurement counters and results.
REQ-002 SHALL have parameter FILT_LEN, default 3: glitch-filter length in samples (used only when filter compiled in).
REQ-003 SHALL have port CLK, input, 1: single system clock; all logic on posedge CLK.
REQ-004 SHALL have port RST_N, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port PWM_IN, input, 1: asynchronous PWM waveform under measurement.
REQ-006 SHALL have port HIGH_CNT, output, CNT_W: high time of last complete PWM period, in CLK cycles.
REQ-007 SHALL have port PERIOD, output, CNT_W: last complete rising-to-rising period, in CLK cycles.
REQ-008 SHALL have port VALID, output, 1: one-cycle pulse when HIGH_CNT/PERIOD update.
REQ-009 SHALL have port STUCK, output, 1: no edge for 2^CNT_W-1 cycles (0%/100% duty or dead input).
REQ-010 SHALL have port LEVEL, output, 1: current synchronized (filtered) PWM_IN level.

Function
REQ-011 SHALL pass PWM_IN through a 2-flop synchronizer; edges detected by comparing synchronized level with previous cycle.
REQ-012 SHALL implement FSM states IDLE, HIGH, LOW, STUCK.
REQ-013 IDLE: on rising edge -> HIGH, period counter loads 1; no VALID (first period incomplete).
REQ-014 HIGH: falling edge -> LOW, latch period counter into internal high register.
REQ-015 LOW: rising edge -> HIGH; same cycle load PERIOD <= period counter, HIGH_CNT <= internal high register, period counter <= 1; VALID pulses next cycle for exactly one cycle.
REQ-016 Period counter SHALL increment every non-rising-edge cycle and saturate at 2^CNT_W-1, never wrap.
REQ-017 Counter reaching 2^CNT_W-1 in HIGH, LOW or IDLE SHALL -> STUCK, assert STUCK; HIGH_CNT/PERIOD hold last values; no VALID.
REQ-018 STUCK: rising edge -> HIGH as in IDLE (deassert STUCK, no VALID); falling edge -> IDLE (deassert STUCK).
REQ-019 For waveform high H, low L cycles (steady state): HIGH_CNT = H, PERIOD = H+L.
REQ-020 Latency from raw PWM_IN rising edge to VALID SHALL be 3 CLK cycles (filter off).
REQ-021 Pulses shorter than 1 CLK cycle may be missed; no other behaviour guaranteed for them.

Reset
REQ-022 RST_N low SHALL immediately force: state IDLE, HIGH_CNT=0, PERIOD=0, VALID=0, STUCK=0, LEVEL=0, counters and synchronizer flops 0.
REQ-023 Reset mid-period SHALL discard partial measurement; first VALID requires two rising edges after release.

Configuration
REQ-024 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: synchronized level SHALL change only after FILT_LEN consecutive equal samples; latency becomes 3+FILT_LEN cycles; measured H and L unchanged for pulses >= FILT_LEN cycles.
REQ-025 Macro undefined: no filter logic, FILT_LEN ignored, latency per REQ-020.

Structure
REQ-026 Package pwm_capture_pkg SHALL hold FSM state typedef (IDLE/HIGH/LOW/STUCK) and CNT_W default constant.
REQ-027 Sub-module pwm_sync_edge SHALL contain synchronizer, optional glitch filter, rise/fall pulse generation; FSM and counters in pwm_capture.

Verification
REQ-028 30 high/70 low, 5 periods -> 4 VALID pulses, each HIGH_CNT=30, PERIOD=100.
REQ-029 Duty change 30/70 -> 80/20 mid-stream -> first full new period reports HIGH_CNT=80, PERIOD=100.
REQ-030 CNT_W=8, PWM_IN held high 300 cycles -> STUCK=1 at 255 cycles after last edge, LEVEL=1, outputs unchanged; then 10/20 waveform -> STUCK clears, VALID with HIGH_CNT=10, PERIOD=30 after second rising edge.
REQ-031 RST_N low during HIGH phase of 30/70 stream -> all outputs 0 immediately; first VALID after second post-reset rising edge.
REQ-032 Filter compiled, FILT_LEN=3: 2-cycle glitches injected in low phase of 30/70 -> no spurious VALID, values 30/100.
REQ-033 Minimum waveform 1 high/1 low -> VALID every 2 cycles, HIGH_CNT=1, PERIOD=2.
